// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 constants and FSM state type for the load/store unit
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    WRITE  = 3'd4,
    RESP   = 3'd5
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/halfword lane extract with extension, and store-lane merge
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rword[{lane, 3'b000} +: 8];
  assign half_sel = rword[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_data = rword;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = rword;
    endcase
  end

  // Lanes outside the store width keep the word just read from memory.
  always_comb begin
    merged = rword;
    case (funct3)
      F3_B:    merged[{lane, 3'b000} +: 8]     = wdata[7:0];
      F3_H:    merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - load/store initiator for a single-cycle word memory with RMW sub-word stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out
);

  lsu_state_e          state_q, state_d;
  logic [ADDR_W+1:0]   addr_q;
  logic [2:0]          f3_q;
  logic                we_q;
  logic                err_q;
  logic [31:0]         wdata_q;
  logic [31:0]         data_q;
  logic                accept;
  logic                misalign, out_of_range, illegal, req_err;
  logic [31:0]         load_data, merged;

  assign accept = req_valid && req_ready;

  always_comb begin
    misalign     = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
    out_of_range = |req_addr[31:ADDR_W+2];
    illegal      = req_we ? (req_funct3 > F3_W)
                          : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
    req_err      = misalign || out_of_range || illegal;
  end

  lsu_lane_align u_lane_align (
    .funct3    (f3_q),
    .lane      (addr_q[1:0]),
    .rword     (mem_data_out),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr[ADDR_W+1:0];
        f3_q    <= req_funct3;
        we_q    <= req_we;
        err_q   <= req_err;
        wdata_q <= req_wdata;
      end
      // data_q holds the extended load result, or the merged word awaiting write-back.
      if (state_q == LOAD)
        data_q <= load_data;
      else if (state_q == RMW_RD)
        data_q <= merged;
    end
  end

  assign mem_address = addr_q[ADDR_W+1:2];

  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_err     = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_data_in  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)             state_d = RESP;
          else if (!req_we)        state_d = LOAD;
          else if (req_funct3 == F3_W) state_d = WRITE;
          else                     state_d = RMW_RD;
        end
      end
      LOAD: begin
        mem_read_en = 1'b1;
        state_d     = RESP;
      end
      RMW_RD: begin
        mem_read_en = 1'b1;
        state_d     = RMW_WR;
      end
      RMW_WR: begin
        mem_write_en = 1'b1;
        mem_data_in  = data_q;
        state_d      = RESP;
      end
      WRITE: begin
        mem_write_en = 1'b1;
        mem_data_in  = wdata_q;
        state_d      = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? 32'd0 : data_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
